// File: rtl/pong_game_ctrl.sv
// LightPong rally sequencer: ball motion, speed levels, hit windows, scoring and win detection.
// Optional EARLY_SWING_EN turns a premature paddle press (1-3 positions short of the end) into a miss.
module pong_game_ctrl #(
  parameter int STEP_CYCLES = 12_500_000,
  parameter int WIN_SCORE   = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] player,
  output logic [15:0] ball,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic [1:0]  level,
  output logic        game_over,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MOVE_L    = 3'd1,
    S_MOVE_R    = 3'd2,
    S_POINT     = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  // The counter never exceeds STEP_CYCLES-1, which fits in clog2(STEP_CYCLES) bits.
  localparam int             CW         = $clog2(STEP_CYCLES);
  localparam logic [CW-1:0]  BASE_LAST  = CW'(STEP_CYCLES - 1);
  localparam logic [3:0]     WIN        = 4'(WIN_SCORE);
  localparam logic [15:0]    BALL_SERVE = 16'h0100;
  localparam logic [15:0]    BALL_L_END = 16'h8000;
  localparam logic [15:0]    BALL_R_END = 16'h0001;

  logic [15:0]   r_sync1, r_sync2, r_prev;
  logic [15:0]   w_edge;
  logic          w_edge_l, w_edge_r, w_edge_s, w_early_l, w_early_r;
  logic          w_unused_edges;
  state_t        r_state, w_state_nx;
  logic [15:0]   r_ball, w_ball_nx;
  logic [3:0]    r_score_l, w_score_l_nx, r_score_r, w_score_r_nx;
  logic [1:0]    r_level, w_level_nx;
  logic          r_serve_r, w_serve_r_nx;   // 1: next serve travels right
  logic          r_scorer_r, w_scorer_r_nx; // 1: right player won the last point
  logic [CW-1:0] r_cnt, w_cnt_nx, w_last;
  logic [31:0]   w_period;
  logic          w_step;

  assign w_edge         = r_sync2 & ~r_prev;
  assign w_edge_l       = w_edge[15];
  assign w_edge_r       = w_edge[0];
  assign w_edge_s       = w_edge[8];
  assign w_unused_edges = ^{w_edge[14:9], w_edge[7:1]};

`ifdef EARLY_SWING_EN
  assign w_early_l = w_edge_l && (r_ball == 16'h1000 || r_ball == 16'h2000 || r_ball == 16'h4000);
  assign w_early_r = w_edge_r && (r_ball == 16'h0002 || r_ball == 16'h0004 || r_ball == 16'h0008);
`else
  assign w_early_l = 1'b0;
  assign w_early_r = 1'b0;
`endif

  // POINT holds for the base period regardless of the level reached in the rally.
  assign w_period = 32'(STEP_CYCLES) >> r_level;
  assign w_last   = (r_state == S_POINT) ? BASE_LAST : CW'(w_period - 32'd1);
  assign w_step   = (r_cnt == w_last);

  always_comb begin
    w_state_nx    = r_state;
    w_ball_nx     = r_ball;
    w_score_l_nx  = r_score_l;
    w_score_r_nx  = r_score_r;
    w_level_nx    = r_level;
    w_serve_r_nx  = r_serve_r;
    w_scorer_r_nx = r_scorer_r;
    w_cnt_nx      = w_step ? '0 : r_cnt + CW'(1);
    case (r_state)
      S_IDLE: begin
        w_cnt_nx  = '0;
        w_ball_nx = BALL_SERVE;
        if (w_edge_s) w_state_nx = r_serve_r ? S_MOVE_R : S_MOVE_L;
      end
      S_MOVE_L: begin
        if (r_ball == BALL_L_END && w_edge_l) begin
          w_state_nx = S_MOVE_R;
          w_level_nx = (r_level == 2'd3) ? r_level : r_level + 2'd1;
          w_cnt_nx   = '0;
        end else if (w_early_l || (w_step && r_ball == BALL_L_END)) begin
          w_score_r_nx  = (r_score_r == WIN) ? r_score_r : r_score_r + 4'd1;
          w_ball_nx     = '0;
          w_serve_r_nx  = 1'b0;
          w_scorer_r_nx = 1'b1;
          w_state_nx    = S_POINT;
          w_cnt_nx      = '0;
        end else if (w_step) begin
          w_ball_nx = r_ball << 1;
        end
      end
      S_MOVE_R: begin
        if (r_ball == BALL_R_END && w_edge_r) begin
          w_state_nx = S_MOVE_L;
          w_level_nx = (r_level == 2'd3) ? r_level : r_level + 2'd1;
          w_cnt_nx   = '0;
        end else if (w_early_r || (w_step && r_ball == BALL_R_END)) begin
          w_score_l_nx  = (r_score_l == WIN) ? r_score_l : r_score_l + 4'd1;
          w_ball_nx     = '0;
          w_serve_r_nx  = 1'b1;
          w_scorer_r_nx = 1'b0;
          w_state_nx    = S_POINT;
          w_cnt_nx      = '0;
        end else if (w_step) begin
          w_ball_nx = r_ball >> 1;
        end
      end
      S_POINT: begin
        w_ball_nx = '0;
        if (w_step) begin
          w_cnt_nx = '0;
          if ((r_scorer_r ? r_score_r : r_score_l) == WIN) begin
            w_state_nx = S_GAME_OVER;
            w_ball_nx  = 16'hFFFF;
          end else begin
            w_state_nx = S_IDLE;
            w_level_nx = 2'd0;
            w_ball_nx  = BALL_SERVE;
          end
        end
      end
      S_GAME_OVER: begin
        w_cnt_nx  = '0;
        w_ball_nx = 16'hFFFF;
        if (w_edge_s) begin
          w_score_l_nx = '0;
          w_score_r_nx = '0;
          w_level_nx   = 2'd0;
          w_ball_nx    = BALL_SERVE;
          w_state_nx   = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_ball_nx  = BALL_SERVE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_prev     <= '0;
      r_state    <= S_IDLE;
      r_ball     <= BALL_SERVE;
      r_score_l  <= '0;
      r_score_r  <= '0;
      r_level    <= '0;
      r_serve_r  <= 1'b0;
      r_scorer_r <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= player;
      r_sync2    <= r_sync1;
      r_prev     <= r_sync2;
      r_state    <= w_state_nx;
      r_ball     <= w_ball_nx;
      r_score_l  <= w_score_l_nx;
      r_score_r  <= w_score_r_nx;
      r_level    <= w_level_nx;
      r_serve_r  <= w_serve_r_nx;
      r_scorer_r <= w_scorer_r_nx;
      r_cnt      <= w_cnt_nx;
    end
  end

  assign ball      = r_ball;
  assign score_l   = r_score_l;
  assign score_r   = r_score_r;
  assign level     = r_level;
  assign game_over = (r_state == S_GAME_OVER);
  assign state     = r_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl with STEP_CYCLES=8, WIN_SCORE=2; expected output snapshots
// {state, ball, score_l, score_r, level, game_over} flow through exp_q.
module tb_pong_game_ctrl;

  logic        clk;
  logic        reset;
  logic [15:0] player;
  logic [15:0] ball;
  logic [3:0]  score_l, score_r;
  logic [1:0]  level;
  logic        game_over;
  logic [2:0]  state;

  int n_checks = 0;
  int n_errors = 0;
  logic [29:0] exp_q[$];
  logic [29:0] got, exp;
  bit          ok;

  pong_game_ctrl #(.STEP_CYCLES(8), .WIN_SCORE(2)) dut (
    .clk(clk), .reset(reset), .player(player), .ball(ball),
    .score_l(score_l), .score_r(score_r), .level(level),
    .game_over(game_over), .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  function automatic logic [29:0] pk(input logic [2:0] st, input logic [15:0] b,
                                     input logic [3:0] sl, input logic [3:0] sr,
                                     input logic [1:0] lv, input logic go);
    return {st, b, sl, sr, lv, go};
  endfunction

  function automatic logic [29:0] snap();
    return {state, ball, score_l, score_r, level, game_over};
  endfunction

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic serve_pulse();
    player[8] = 1'b0;
    tick(2);
    player[8] = 1'b1;
    tick(4);
    player[8] = 1'b0;
  endtask

  task automatic wait_for(input logic [2:0] st, input logic [15:0] b, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (state === st && ball === b) begin
        found = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    player = '0;
    tick(2);
    reset = 1'b0;
    exp_q.push_back(pk(3'd0, 16'h0100, 4'd0, 4'd0, 2'd0, 1'b0));
    tick(1);
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL reset_state got=%h exp=%h", got, exp); end
  endtask

  task automatic test_serve();
    player[8] = 1'b1;
    exp_q.push_back(pk(3'd1, 16'h0100, 4'd0, 4'd0, 2'd0, 1'b0));
    tick(3);
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL serve_latency got=%h exp=%h", got, exp); end
    tick(1);
    player[8] = 1'b0;
    exp_q.push_back(pk(3'd1, 16'h0100, 4'd0, 4'd0, 2'd0, 1'b0));
    tick(6);
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL before_first_step got=%h exp=%h", got, exp); end
    exp_q.push_back(pk(3'd1, 16'h0200, 4'd0, 4'd0, 2'd0, 1'b0));
    tick(1);
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL first_step got=%h exp=%h", got, exp); end
    exp_q.push_back(pk(3'd1, 16'h8000, 4'd0, 4'd0, 2'd0, 1'b0));
    tick(48);
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL reach_left_end got=%h exp=%h", got, exp); end
  endtask

  task automatic test_hit_left();
    player[15] = 1'b1;
    exp_q.push_back(pk(3'd2, 16'h8000, 4'd0, 4'd0, 2'd1, 1'b0));
    tick(3);
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL left_hit got=%h exp=%h", got, exp); end
    player[15] = 1'b0;
    exp_q.push_back(pk(3'd2, 16'h8000, 4'd0, 4'd0, 2'd1, 1'b0));
    tick(3);
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL hit_timer_cleared got=%h exp=%h", got, exp); end
    exp_q.push_back(pk(3'd2, 16'h4000, 4'd0, 4'd0, 2'd1, 1'b0));
    tick(1);
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL level1_step got=%h exp=%h", got, exp); end
    // opposite paddle and serve presses while moving right are ignored
    player[15] = 1'b1;
    player[8]  = 1'b1;
    exp_q.push_back(pk(3'd2, 16'h2000, 4'd0, 4'd0, 2'd1, 1'b0));
    tick(4);
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL ignore_opposite got=%h exp=%h", got, exp); end
    player[15] = 1'b0;
    player[8]  = 1'b0;
  endtask

  task automatic test_hit_right();
    exp_q.push_back(pk(3'd2, 16'h0001, 4'd0, 4'd0, 2'd1, 1'b0));
    tick(52);
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL reach_right_end got=%h exp=%h", got, exp); end
    player[0] = 1'b1;
    exp_q.push_back(pk(3'd1, 16'h0001, 4'd0, 4'd0, 2'd2, 1'b0));
    tick(3);
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL right_hit_beats_step got=%h exp=%h", got, exp); end
    player[0] = 1'b0;
    exp_q.push_back(pk(3'd1, 16'h0002, 4'd0, 4'd0, 2'd2, 1'b0));
    tick(2);
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL level2_step got=%h exp=%h", got, exp); end
  endtask

  task automatic test_miss_left();
    exp_q.push_back(pk(3'd1, 16'h8000, 4'd0, 4'd0, 2'd2, 1'b0));
    tick(29);
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL before_miss got=%h exp=%h", got, exp); end
    exp_q.push_back(pk(3'd3, 16'h0000, 4'd0, 4'd1, 2'd2, 1'b0));
    tick(1);
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL left_miss got=%h exp=%h", got, exp); end
    exp_q.push_back(pk(3'd3, 16'h0000, 4'd0, 4'd1, 2'd2, 1'b0));
    tick(7);
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL point_hold got=%h exp=%h", got, exp); end
    exp_q.push_back(pk(3'd0, 16'h0100, 4'd0, 4'd1, 2'd0, 1'b0));
    tick(1);
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL point_to_idle got=%h exp=%h", got, exp); end
    player[8] = 1'b1;
    exp_q.push_back(pk(3'd1, 16'h0100, 4'd0, 4'd1, 2'd0, 1'b0));
    tick(3);
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL serve_toward_loser got=%h exp=%h", got, exp); end
    player[8] = 1'b0;
  endtask

  task automatic test_game_over();
    exp_q.push_back(pk(3'd1, 16'h8000, 4'd0, 4'd1, 2'd0, 1'b0));
    tick(63);
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL second_rally_end got=%h exp=%h", got, exp); end
    exp_q.push_back(pk(3'd3, 16'h0000, 4'd0, 4'd2, 2'd0, 1'b0));
    tick(1);
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL winning_point got=%h exp=%h", got, exp); end
    exp_q.push_back(pk(3'd4, 16'hFFFF, 4'd0, 4'd2, 2'd0, 1'b1));
    tick(8);
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL game_over got=%h exp=%h", got, exp); end
    player[15] = 1'b1;
    tick(1);
    player[15] = 1'b0;
    exp_q.push_back(pk(3'd4, 16'hFFFF, 4'd0, 4'd2, 2'd0, 1'b1));
    tick(3);
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL game_over_ignores_paddle got=%h exp=%h", got, exp); end
    player[8] = 1'b1;
    exp_q.push_back(pk(3'd0, 16'h0100, 4'd0, 4'd0, 2'd0, 1'b0));
    tick(3);
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL new_game got=%h exp=%h", got, exp); end
    player[8] = 1'b0;
  endtask

  task automatic test_reset_mid_rally();
    serve_pulse();
    wait_for(3'd1, 16'h8000, 80, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL wait_left_end got=%h exp=ball 8000", snap()); end
    player[15] = 1'b1;
    exp_q.push_back(pk(3'd2, 16'h8000, 4'd0, 4'd0, 2'd1, 1'b0));
    tick(3);
    player[15] = 1'b0;
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL rally_left_hit got=%h exp=%h", got, exp); end
    wait_for(3'd3, 16'h0000, 100, ok);
    exp_q.push_back(pk(3'd3, 16'h0000, 4'd1, 4'd0, 2'd1, 1'b0));
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (!ok || got !== exp) begin n_errors++; $display("FAIL right_miss got=%h exp=%h", got, exp); end
    wait_for(3'd0, 16'h0100, 20, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL wait_idle got=%h exp=state 0", snap()); end
    serve_pulse();
    exp_q.push_back(pk(3'd2, 16'h0100, 4'd1, 4'd0, 2'd0, 1'b0));
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL serve_right got=%h exp=%h", got, exp); end
    tick(10);
    #2 reset = 1'b1;
    exp_q.push_back(pk(3'd0, 16'h0100, 4'd0, 4'd0, 2'd0, 1'b0));
    #1;
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL async_reset got=%h exp=%h", got, exp); end
    tick(2);
    reset = 1'b0;
    serve_pulse();
    exp_q.push_back(pk(3'd1, 16'h0100, 4'd0, 4'd0, 2'd0, 1'b0));
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL serve_dir_after_reset got=%h exp=%h", got, exp); end
  endtask

  task automatic test_early_swing();
    wait_for(3'd1, 16'h8000, 80, ok);
    player[15] = 1'b1;
    tick(3);
    player[15] = 1'b0;
    wait_for(3'd2, 16'h0004, 80, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL wait_ball_0004 got=%h exp=state 2 ball 0004", snap()); end
    player[0] = 1'b1;
`ifdef EARLY_SWING_EN
    exp_q.push_back(pk(3'd3, 16'h0000, 4'd1, 4'd0, 2'd1, 1'b0));
    exp_q.push_back(pk(3'd3, 16'h0000, 4'd1, 4'd0, 2'd1, 1'b0));
`else
    exp_q.push_back(pk(3'd2, 16'h0004, 4'd0, 4'd0, 2'd1, 1'b0));
    exp_q.push_back(pk(3'd2, 16'h0002, 4'd0, 4'd0, 2'd1, 1'b0));
`endif
    tick(3);
    player[0] = 1'b0;
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL early_press got=%h exp=%h", got, exp); end
    tick(1);
    got = snap(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL early_press_after got=%h exp=%h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_hit_left();
    test_hit_right();
    test_miss_left();
    test_game_over();
    test_reset_mid_rally();
    test_early_swing();
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
